// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: time-multiplexed FIR filter built around a single
// multiply-accumulate unit. Each accepted sample is written into a circular
// delay line. An external coefficient ROM is then stepped once per tap, and
// the scaled sum is presented with a one-cycle output_ready pulse.
// Optional build macro FIR_SATURATE_EN: when defined, the scaled result is
// clamped to the signed DATA_W range. When it is undefined, the result wraps
// to its low DATA_W bits.
module fir_mac_sequencer #(
    parameter int DATA_W    = 24,
    parameter int COEF_W    = 16,
    parameter int NTAPS     = 16,
    parameter int COEF_FRAC = 15
) (
    input  logic                     ck,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] in,
    input  logic                     input_ready,
    output logic [$clog2(NTAPS)-1:0] coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic signed [DATA_W-1:0] out,
    output logic                     output_ready,
    output logic                     busy,
    output logic                     overrun
);

    localparam int AW     = $clog2(NTAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + AW;

    localparam logic [AW-1:0] ONE       = AW'(1);
    localparam logic [AW-1:0] LAST_TAP  = AW'(NTAPS - 1);
    localparam logic [AW-1:0] TAPS_MOD  = AW'(NTAPS);

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DRAIN,
        DONE
    } state_t;

    state_t                    state;
    logic                      prev_rdy;
    logic signed [DATA_W-1:0]  delay_line [NTAPS];
    logic [AW-1:0]             wr_ptr;
    logic [AW-1:0]             base;
    logic [AW-1:0]             k;
    logic signed [DATA_W-1:0]  sample_q;
    logic signed [ACC_W-1:0]   acc;

    logic                      strobe_edge;
    logic [AW-1:0]             rd_idx;
    logic [AW-1:0]             wr_next;
    logic signed [PROD_W-1:0]  product;
    logic signed [ACC_W-1:0]   acc_sum;
    logic signed [DATA_W-1:0]  result;

    // A strobe held high for several cycles counts as a single sample.
    assign strobe_edge = input_ready & ~prev_rdy;

    // The ROM data lags its address by one cycle, so the product always pairs
    // this cycle's coefficient with the sample fetched in the previous cycle.
    assign product = PROD_W'(coef_data) * PROD_W'(sample_q);
    assign acc_sum = acc + ACC_W'(product);

    // Walk backwards from the newest sample, wrapping around the circular buffer.
    always_comb begin
        rd_idx = base - k;
        if (base < k) begin
            rd_idx = base - k + TAPS_MOD;
        end
        wr_next = wr_ptr + ONE;
        if (wr_ptr == LAST_TAP) begin
            wr_next = '0;
        end
    end

`ifdef FIR_SATURATE_EN
    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [ACC_W-1:0] scaled;
    assign scaled = acc_sum >>> COEF_FRAC;

    // Clamp the floor-scaled sum into the representable output range.
    always_comb begin
        result = scaled[DATA_W-1:0];
        if (scaled > MAX_V) begin
            result = MAX_V[DATA_W-1:0];
        end else if (scaled < MIN_V) begin
            result = MIN_V[DATA_W-1:0];
        end
    end
`else
    assign result = DATA_W'(acc_sum >>> COEF_FRAC);
`endif

    // Sequencer: capture sample, step through the taps, drain the pipeline, publish.
    always_ff @(posedge ck) begin
        if (rst) begin
            state        <= IDLE;
            prev_rdy     <= 1'b0;
            wr_ptr       <= '0;
            base         <= '0;
            k            <= '0;
            sample_q     <= '0;
            acc          <= '0;
            out          <= '0;
            output_ready <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
            coef_addr    <= '0;
            for (int i = 0; i < NTAPS; i++) begin
                delay_line[i] <= '0;
            end
        end else begin
            prev_rdy     <= input_ready;
            output_ready <= 1'b0;
            if (strobe_edge && (state != IDLE)) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (strobe_edge) begin
                        delay_line[wr_ptr] <= in;
                        base      <= wr_ptr;
                        wr_ptr    <= wr_next;
                        acc       <= '0;
                        k         <= '0;
                        coef_addr <= '0;
                        busy      <= 1'b1;
                        state     <= MAC;
                    end
                end
                MAC: begin
                    sample_q <= delay_line[rd_idx];
                    if (k != '0) begin
                        acc <= acc_sum;
                    end
                    if (k == LAST_TAP) begin
                        state <= DRAIN;
                    end else begin
                        k         <= k + ONE;
                        coef_addr <= k + ONE;
                    end
                end
                DRAIN: begin
                    acc          <= acc_sum;
                    out          <= result;
                    output_ready <= 1'b1;
                    state        <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer. It uses a registered coefficient
// ROM model and a reference filter built from a queue of accepted samples
// (newest first).
// Expected results follow FIR_SATURATE_EN in the same way the design does.
module tb_fir_mac_sequencer;

    localparam int DATA_W    = 24;
    localparam int COEF_W    = 16;
    localparam int NTAPS     = 16;
    localparam int COEF_FRAC = 15;
    localparam int LATENCY   = NTAPS + 2;

`ifdef FIR_SATURATE_EN
    localparam longint SAT_EXPECT = 8388607;
`else
    localparam longint SAT_EXPECT = -4112;
`endif

    typedef struct {
        longint v;
        int     hold;
        int     gap;
        longint expect_out;
    } vec_t;

    logic                     ck = 1'b0;
    logic                     rst = 1'b1;
    logic signed [DATA_W-1:0] in_s = '0;
    logic                     input_ready = 1'b0;
    logic [$clog2(NTAPS)-1:0] coef_addr;
    logic signed [COEF_W-1:0] coef_data;
    logic signed [DATA_W-1:0] out_s;
    logic                     output_ready;
    logic                     busy;
    logic                     overrun;

    logic signed [COEF_W-1:0] rom [NTAPS];
    int                       cyc = 0;
    int                       errors = 0;
    int                       checks = 0;
    longint                   hist[$];
    vec_t                     imp_vecs[$];
    vec_t                     step_vecs[$];

    fir_mac_sequencer #(
        .DATA_W   (DATA_W),
        .COEF_W   (COEF_W),
        .NTAPS    (NTAPS),
        .COEF_FRAC(COEF_FRAC)
    ) dut (
        .ck          (ck),
        .rst         (rst),
        .in          (in_s),
        .input_ready (input_ready),
        .coef_addr   (coef_addr),
        .coef_data   (coef_data),
        .out         (out_s),
        .output_ready(output_ready),
        .busy        (busy),
        .overrun     (overrun)
    );

    // 100 MHz-style free-running clock; absolute period is irrelevant here.
    always #5 ck = ~ck;

    // Cycle counter used to measure strobe-to-result latency.
    always @(posedge ck) cyc <= cyc + 1;

    // Synchronous coefficient ROM: data appears the cycle after its address.
    always @(posedge ck) coef_data <= rom[coef_addr];

    // Hard stop in case something hangs beyond every bounded wait.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic void model_reset();
        hist.delete();
        for (int i = 0; i < NTAPS; i++) hist.push_back(0);
    endfunction

    function automatic void model_accept(input longint v);
        hist.push_front(v);
        void'(hist.pop_back());
    endfunction

    // Plain convolution of the last NTAPS accepted samples, then floor scaling.
    function automatic longint model_out();
        longint acc;
        logic signed [DATA_W-1:0] wrapped;
        acc = 0;
        for (int i = 0; i < NTAPS; i++) acc += longint'(rom[i]) * hist[i];
        acc = acc >>> COEF_FRAC;
`ifdef FIR_SATURATE_EN
        if (acc > 8388607) acc = 8388607;
        if (acc < -8388608) acc = -8388608;
        return acc;
`else
        wrapped = acc[DATA_W-1:0];
        return longint'(wrapped);
`endif
    endfunction

    function automatic void set_rom_ramp();
        for (int i = 0; i < NTAPS; i++) rom[i] = COEF_W'(i + 1);
    endfunction

    function automatic void set_rom_const(input int c);
        for (int i = 0; i < NTAPS; i++) rom[i] = COEF_W'(c);
    endfunction

    task automatic doReset();
        @(negedge ck);
        rst = 1'b1;
        input_ready = 1'b0;
        in_s = '0;
        repeat (2) @(negedge ck);
        rst = 1'b0;
        model_reset();
    endtask

    // Raise the strobe for 'hold' cycles and wait, bounded, for the result pulse.
    task automatic applyStimulus(input longint v, input int hold, output int lat, output bit got);
        int start;
        @(negedge ck);
        in_s = DATA_W'(v);
        input_ready = 1'b1;
        start = cyc;
        got = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge ck);
            if (i >= hold) input_ready = 1'b0;
            if (output_ready) begin
                got = 1'b1;
                lat = cyc - start;
                break;
            end
        end
        input_ready = 1'b0;
    endtask

    task automatic runSample(input string name, input longint v, input int hold, input int gap,
                             input longint expect_out);
        int lat;
        bit got;
        repeat (gap) @(negedge ck);
        applyStimulus(v, hold, lat, got);
        checkOutput({name, " ready"}, longint'(got), 1);
        if (got) begin
            checkOutput({name, " latency"}, lat, LATENCY);
            checkOutput({name, " out"}, out_s, expect_out);
        end
        @(negedge ck);
        checkOutput({name, " pulse width"}, output_ready, 0);
    endtask

    initial begin
        int lat;
        int pulses;
        int start;
        bit got;
        longint out_at_ready;
        logic signed [DATA_W-1:0] r;

        for (int n = 0; n < 18; n++) begin
            imp_vecs.push_back('{v: (n == 0) ? 32768 : 0, hold: 1, gap: 0,
                                 expect_out: (n < NTAPS) ? n + 1 : 0});
        end
        for (int n = 1; n <= 17; n++) begin
            step_vecs.push_back('{v: 10000, hold: 1, gap: 5,
                                  expect_out: (n < NTAPS) ? (625 * n) / 2 : 5000});
        end

        set_rom_ramp();
        model_reset();

        // Reset behaviour and quiet outputs afterwards.
        repeat (2) @(negedge ck);
        checkOutput("reset out", out_s, 0);
        checkOutput("reset output_ready", output_ready, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset overrun", overrun, 0);
        checkOutput("reset coef_addr", coef_addr, 0);
        rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            model_accept(0);
            runSample("zero after reset", 0, 1, 0, 0);
        end

        // Impulse through a ramp of coefficients: the coefficients reappear in order.
        $display("[TB] impulse response");
        foreach (imp_vecs[i]) begin
            model_accept(imp_vecs[i].v);
            runSample($sformatf("impulse[%0d]", i), imp_vecs[i].v, imp_vecs[i].hold,
                      imp_vecs[i].gap, imp_vecs[i].expect_out);
        end

        // Step response at the nominal sample period.
        $display("[TB] step response");
        doReset();
        set_rom_const(1024);
        foreach (step_vecs[i]) begin
            model_accept(step_vecs[i].v);
            runSample($sformatf("step[%0d]", i), step_vecs[i].v, step_vecs[i].hold,
                      step_vecs[i].gap, step_vecs[i].expect_out);
        end

        // Held strobe counts once; a second edge mid-computation is dropped.
        $display("[TB] overrun and held strobe");
        set_rom_ramp();
        checkOutput("overrun clear before", overrun, 0);
        model_accept(300000);
        @(negedge ck);
        in_s = 300000;
        input_ready = 1'b1;
        start = cyc;
        pulses = 0;
        lat = -1;
        out_at_ready = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge ck);
            if (i == 3) input_ready = 1'b0;
            if (i == 4) checkOutput("held strobe no overrun", overrun, 0);
            if (i == 5) begin
                in_s = -2000000;
                input_ready = 1'b1;
            end
            if (i == 6) input_ready = 1'b0;
            if (output_ready) begin
                pulses++;
                if (lat < 0) begin
                    lat = cyc - start;
                    out_at_ready = out_s;
                end
            end
        end
        checkOutput("overrun single pulse", pulses, 1);
        checkOutput("overrun latency", lat, LATENCY);
        checkOutput("overrun out", out_at_ready, model_out());
        checkOutput("overrun sticky", overrun, 1);
        checkOutput("overrun busy idle", busy, 0);
        model_accept(0);
        runSample("after dropped", 0, 1, 0, model_out());
        model_accept(12345);
        runSample("after dropped 2", 12345, 1, 0, model_out());

        // Edge during DONE is an overrun; the edge one cycle later is accepted.
        $display("[TB] DONE-cycle boundary");
        doReset();
        model_accept(100000);
        applyStimulus(100000, 1, lat, got);
        checkOutput("done edge first ready", longint'(got), 1);
        in_s = 5555;
        input_ready = 1'b1;
        @(negedge ck);
        input_ready = 1'b0;
        checkOutput("done edge overrun", overrun, 1);
        checkOutput("done edge busy", busy, 0);
        model_accept(-70000);
        applyStimulus(-70000, 1, lat, got);
        checkOutput("back-to-back A ready", longint'(got), 1);
        checkOutput("back-to-back A out", out_s, model_out());
        model_accept(250000);
        applyStimulus(250000, 1, lat, got);
        checkOutput("back-to-back B ready", longint'(got), 1);
        checkOutput("back-to-back B latency", lat, LATENCY);
        checkOutput("back-to-back B out", out_s, model_out());

        // Large products: clamp or wrap depending on the build.
        $display("[TB] saturation");
        doReset();
        set_rom_const(32767);
        for (int n = 0; n < NTAPS; n++) begin
            model_accept(8388607);
            runSample($sformatf("sat[%0d]", n), 8388607, 1, 0, model_out());
        end
        checkOutput("saturation final", out_s, SAT_EXPECT);

        // Reset in the middle of MAC: no result and a cleared delay line.
        $display("[TB] reset mid-MAC");
        set_rom_ramp();
        @(negedge ck);
        in_s = 4242;
        input_ready = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge ck);
            if (i == 1) input_ready = 1'b0;
            if (i == 5) rst = 1'b1;
            if (i == 6) begin
                checkOutput("busy after mid reset", busy, 0);
                checkOutput("overrun after mid reset", overrun, 0);
                rst = 1'b0;
            end
            if (output_ready) pulses++;
        end
        checkOutput("no ready after mid reset", pulses, 0);
        checkOutput("coef_addr after mid reset", coef_addr, 0);
        checkOutput("out after mid reset", out_s, 0);
        model_reset();
        model_accept(32768);
        runSample("clean impulse 1", 32768, 1, 0, 1);
        model_accept(0);
        runSample("clean impulse 2", 0, 1, 0, 2);

        // Randomized coefficients, samples, strobe widths and gaps.
        $display("[TB] random");
        doReset();
        for (int i = 0; i < NTAPS; i++) rom[i] = COEF_W'($urandom);
        for (int n = 0; n < 40; n++) begin
            r = DATA_W'($urandom);
            model_accept(longint'(r));
            runSample($sformatf("random[%0d]", n), longint'(r), $urandom_range(1, 3),
                      $urandom_range(0, 3), model_out());
        end
        checkOutput("random no overrun", overrun, 0);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
